// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller:
// FSM state enum, forwarding-source enum and stall counter width.
package pipeline_hazard_ctrl_pkg;

   localparam int STALL_CNT_W = 16;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      STALL    = 2'd1,
      MEM_WAIT = 2'd2
   } hz_state_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2
   } fwd_sel_t;

   // The younger MEM-stage result shadows the older WB write data.
   function automatic fwd_sel_t fwd_pick(input logic mem_hit,
                                         input logic wb_hit);
      if (mem_hit) return FWD_MEM;
      if (wb_hit)  return FWD_WB;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// master: datapath side (drives register/stage info, reads controls).
// slave : controller side (reads stage info, drives enables/forwarding/debug).
interface pipeline_hazard_ctrl_if
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 3
);
   logic [REG_ADDR_W-1:0]  id_rs1;
   logic [REG_ADDR_W-1:0]  id_rs2;
   logic                   id_use_rs1;
   logic                   id_use_rs2;
   logic [REG_ADDR_W-1:0]  ex_rs1;
   logic [REG_ADDR_W-1:0]  ex_rs2;
   logic [REG_ADDR_W-1:0]  ex_rd;
   logic [REG_ADDR_W-1:0]  mem_rd;
   logic [REG_ADDR_W-1:0]  wb_rd;
   logic                   ex_wr_en;
   logic                   mem_wr_en;
   logic                   wb_wr_en;
   logic                   ex_is_load;
   logic                   ex_branch_taken;
   logic                   mem_busy;
   logic                   pc_en;
   logic                   pr1_en;
   logic                   pr2_en;
   logic                   pr3_en;
   logic                   pr4_en;
   logic                   pr1_flush;
   logic                   pr2_bubble;
   logic [1:0]             fwd_a;
   logic [1:0]             fwd_b;
   logic [STALL_CNT_W-1:0] stall_cnt;
   logic                   mem_timeout;
   logic [1:0]             state;

   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
      output ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
      output ex_wr_en, mem_wr_en, wb_wr_en,
      output ex_is_load, ex_branch_taken, mem_busy,
      input  pc_en, pr1_en, pr2_en, pr3_en, pr4_en,
      input  pr1_flush, pr2_bubble, fwd_a, fwd_b,
      input  stall_cnt, mem_timeout, state
   );

   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
      input  ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd,
      input  ex_wr_en, mem_wr_en, wb_wr_en,
      input  ex_is_load, ex_branch_taken, mem_busy,
      output pc_en, pr1_en, pr2_en, pr3_en, pr4_en,
      output pr1_flush, pr2_bubble, fwd_a, fwd_b,
      output stall_cnt, mem_timeout, state
   );

endinterface

// File: rtl/hazard_raw_cmp.sv
// Single read-after-write check: one source register vs one destination.
// Ports: src/src_used, dst/wr_en in; hit out (never set for register 0).
module hazard_raw_cmp
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int W = 3
) (
   input  logic [W-1:0] src,
   input  logic         src_used,
   input  logic [W-1:0] dst,
   input  logic         wr_en,
   output logic         hit
);

   assign hit = src_used & wr_en & (dst != '0) & (src == dst);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: stalls, flushes, forwarding,
// memory-wait freeze with timeout, stall counter.
// Ports: clk, rst (sync, active-high), hz (pipeline_hazard_ctrl_if.slave).
// Macro HAZARD_FORWARDING_EN: load-use stall + forwarding; otherwise
// every RAW hit stalls and forwarding stays at the register file.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W  = 3,
   parameter int MEM_TIMEOUT = 64
) (
   input logic                 clk,
   input logic                 rst,
   pipeline_hazard_ctrl_if.slave hz
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   hz_state_t              state, state_nxt;
   logic [STALL_CNT_W-1:0] stall_cnt;
   logic [WAIT_W-1:0]      wait_cnt;
   logic                   mem_timeout;

   logic [REG_ADDR_W-1:0]  id_src [2];
   logic                   id_use [2];
   logic [REG_ADDR_W-1:0]  ex_src [2];
   logic [REG_ADDR_W-1:0]  dst    [3];
   logic                   dst_wr [3];
   wire  [2:0]             id_hit [2];
   wire  [1:0]             ex_hit [2];

   assign id_src[0] = hz.id_rs1;
   assign id_src[1] = hz.id_rs2;
   assign id_use[0] = hz.id_use_rs1;
   assign id_use[1] = hz.id_use_rs2;
   assign ex_src[0] = hz.ex_rs1;
   assign ex_src[1] = hz.ex_rs2;
   assign dst[0]    = hz.ex_rd;
   assign dst[1]    = hz.mem_rd;
   assign dst[2]    = hz.wb_rd;
   assign dst_wr[0] = hz.ex_wr_en;
   assign dst_wr[1] = hz.mem_wr_en;
   assign dst_wr[2] = hz.wb_wr_en;

   // id_hit[s][d]: ID source s vs EX/MEM/WB dest d.
   // ex_hit[s][d]: EX source s vs MEM/WB dest d.
   for (genvar s = 0; s < 2; s++) begin : g_src
      for (genvar d = 0; d < 3; d++) begin : g_id
         hazard_raw_cmp #(.W(REG_ADDR_W)) u_id (
            .src      (id_src[s]),
            .src_used (id_use[s]),
            .dst      (dst[d]),
            .wr_en    (dst_wr[d]),
            .hit      (id_hit[s][d])
         );
      end
      for (genvar d = 1; d < 3; d++) begin : g_ex
         hazard_raw_cmp #(.W(REG_ADDR_W)) u_ex (
            .src      (ex_src[s]),
            .src_used (1'b1),
            .dst      (dst[d]),
            .wr_en    (dst_wr[d]),
            .hit      (ex_hit[s][d-1])
         );
      end
   end

   logic     load_use;
   logic     need_stall;
   fwd_sel_t fwd_a_sel, fwd_b_sel;

   assign load_use = hz.ex_is_load & (id_hit[0][0] | id_hit[1][0]);

`ifdef HAZARD_FORWARDING_EN
   // The bubble already separates load and consumer in STALL.
   assign need_stall = load_use & (state != STALL);
   assign fwd_a_sel  = fwd_pick(ex_hit[0][0], ex_hit[0][1]);
   assign fwd_b_sel  = fwd_pick(ex_hit[1][0], ex_hit[1][1]);
   logic unused_raw;
   assign unused_raw = ^{id_hit[0][2:1], id_hit[1][2:1]};
`else
   // No bypass: hold ID until the producer has left WB.
   assign need_stall = (|id_hit[0]) | (|id_hit[1]);
   assign fwd_a_sel  = FWD_RF;
   assign fwd_b_sel  = FWD_RF;
   logic unused_fwd;
   assign unused_fwd = ^{ex_hit[0], ex_hit[1], load_use};
`endif

   logic go_rst, go_busy, go_br, go_stall;
   logic pc_en, pr1_en, prx_en, pr1_flush, pr2_bubble;

   assign go_rst   = rst;
   assign go_busy  = ~rst & hz.mem_busy;
   assign go_br    = ~rst & ~hz.mem_busy & hz.ex_branch_taken;
   assign go_stall = ~rst & ~hz.mem_busy & ~hz.ex_branch_taken
                     & need_stall;

   always_comb begin
      state_nxt  = RUN;
      pc_en      = 1'b1;
      pr1_en     = 1'b1;
      prx_en     = 1'b1;
      pr1_flush  = 1'b0;
      pr2_bubble = 1'b0;
      unique case (1'b1)
         go_rst: begin
            pc_en      = 1'b0;
            pr1_en     = 1'b0;
            prx_en     = 1'b0;
            pr1_flush  = 1'b1;
            pr2_bubble = 1'b1;
         end
         go_busy: begin
            pc_en     = 1'b0;
            pr1_en    = 1'b0;
            prx_en    = 1'b0;
            state_nxt = MEM_WAIT;
         end
         go_br: begin
            pr1_flush  = 1'b1;
            pr2_bubble = 1'b1;
         end
         go_stall: begin
            pc_en      = 1'b0;
            pr1_en     = 1'b0;
            pr2_bubble = 1'b1;
            state_nxt  = STALL;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         stall_cnt   <= '0;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state <= state_nxt;
         if (!pc_en && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
         if (hz.mem_busy) begin
            if (wait_cnt != WAIT_W'(MEM_TIMEOUT))
               wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1))
               mem_timeout <= 1'b1;
         end else begin
            wait_cnt <= '0;
         end
      end
   end

   assign hz.pc_en       = pc_en;
   assign hz.pr1_en      = pr1_en;
   assign hz.pr2_en      = prx_en;
   assign hz.pr3_en      = prx_en;
   assign hz.pr4_en      = prx_en;
   assign hz.pr1_flush   = pr1_flush;
   assign hz.pr2_bubble  = pr2_bubble;
   assign hz.fwd_a       = rst ? FWD_RF : fwd_a_sel;
   assign hz.fwd_b       = rst ? FWD_RF : fwd_b_sel;
   assign hz.stall_cnt   = stall_cnt;
   assign hz.mem_timeout = mem_timeout;
   assign hz.state       = state;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 3, register-file address width.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 64, MEM_WAIT cycles before mem_timeout sets.
REQ-003 SHALL use one clock; reset is synchronous and active-high: clk  input  1  rising-edge clock.
REQ-004 SHALL provide rst  input  1  synchronous active-high reset.
REQ-005 SHALL provide id_rs1, id_rs2  input  REG_ADDR_W each  source registers of the instruction in ID.
REQ-006 SHALL provide id_use_rs1, id_use_rs2  input  1 each  ID instruction reads that source.
REQ-007 SHALL provide ex_rs1, ex_rs2  input  REG_ADDR_W each  source registers of the instruction in EX.
REQ-008 SHALL provide ex_rd, mem_rd, wb_rd  input  REG_ADDR_W each  destination register per stage.
REQ-009 SHALL provide ex_wr_en, mem_wr_en, wb_wr_en  input  1 each  stage writes the register file.
REQ-010 SHALL provide ex_is_load  input  1  EX instruction is a memory load.
REQ-011 SHALL provide ex_branch_taken  input  1  taken branch resolved in EX.
REQ-012 SHALL provide mem_busy  input  1  data memory needs more cycles for the access in MEM.
REQ-013 SHALL provide pc_en, pr1_en, pr2_en, pr3_en, pr4_en  output  1 each  PC and pipeline-register load enables.
REQ-014 SHALL provide pr1_flush, pr2_bubble  output  1 each  zero IF/ID; load NOP into ID/EX.
REQ-015 SHALL provide fwd_a, fwd_b  output  2 each  EX operand source: 0 RF, 1 MEM-stage ALU result, 2 WB write data.
REQ-016 SHALL provide stall_cnt  output  16  saturating count of cycles with pc_en=0.
REQ-017 SHALL provide mem_timeout  output  1  sticky MEM_WAIT timeout flag.
REQ-018 SHALL provide state  output  2  FSM state for debug.

Function
REQ-019 SHALL implement FSM states RUN=0, STALL=1, MEM_WAIT=2; control outputs combinational from registered state plus current inputs; state, counters, mem_timeout registered.
REQ-020 SHALL never flag a hazard or forward for register 0.
REQ-021 SHALL define load_use = ex_wr_en & ex_is_load & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-022 SHALL apply priority mem_busy > ex_branch_taken > load_use in every state.
REQ-023 mem_busy=1: all five enables 0, pr1_flush=0, pr2_bubble=0; next state MEM_WAIT; return to RUN on the first cycle with mem_busy=0.
REQ-024 ex_branch_taken=1 (no mem_busy): all enables 1, pr1_flush=1, pr2_bubble=1; next state RUN.
REQ-025 load_use=1 in RUN: pc_en=pr1_en=0, pr2_bubble=1, other enables 1; next state STALL.
REQ-026 STALL SHALL last exactly one cycle with load_use ignored, then return to RUN.
REQ-027 fwd_a SHALL be 1 if mem_wr_en & mem_rd==ex_rs1, else 2 if wb_wr_en & wb_rd==ex_rs1, else 0 (MEM wins); fwd_b likewise for ex_rs2.
REQ-028 stall_cnt SHALL increment every cycle pc_en=0 and saturate at 16'hFFFF.
REQ-029 SHALL count consecutive MEM_WAIT cycles; at MEM_TIMEOUT set mem_timeout (held until rst); freeze continues while mem_busy=1.

Reset
REQ-030 While rst=1, all enables SHALL be 0, pr1_flush=1, pr2_bubble=1, fwd_a=fwd_b=0.
REQ-031 After a rst cycle, state=RUN, stall_cnt=0, wait count=0, mem_timeout=0, including reset during MEM_WAIT or STALL.

Configuration
REQ-032 With HAZARD_FORWARDING_EN defined, behaviour SHALL be as REQ-021..REQ-027.
REQ-033 Without it, fwd_a=fwd_b=0; any ID source matching an enabled EX, MEM or WB destination SHALL stall as REQ-025, every cycle, until cleared; STALL suppression is not applied.

Structure
REQ-034 The shared package SHALL hold the state enum, fwd_sel_t enum (FWD_RF, FWD_MEM, FWD_WB) and STALL_CNT_W=16.
REQ-035 SHALL instantiate sub-module hazard_raw_cmp (one source vs one destination, wr_en, zero-register mask) per comparison.

Verification
REQ-036 ex_rd=3, ex_is_load=1, id_rs1=3 used -> one cycle pc_en=pr1_en=0, pr2_bubble=1, state=STALL, next cycle RUN, fwd_a=2.
REQ-037 mem_rd=5 and wb_rd=5 both enabled, ex_rs2=5 -> fwd_b=1; ex_rs2=0 -> fwd_b=0.
REQ-038 ex_branch_taken=1 with load_use=1 -> pr1_flush=1, pr2_bubble=1, pc_en=1, no STALL.
REQ-039 mem_busy held 70 cycles, MEM_TIMEOUT=64 -> enables 0 for 70 cycles, mem_timeout=1 from cycle 64, stall_cnt=70.
REQ-040 rst asserted in MEM_WAIT -> next cycle state=RUN, stall_cnt=0, mem_timeout=0.
REQ-041 Without HAZARD_FORWARDING_EN, ALU write r2 followed by read of r2 -> stall until WB retires r2 (3 cycles).
